// File: rtl/lock_sequencer.sv
// Canal-lock passage sequencer: latches boat arrivals, drives the water stage
// and times both gates. Only one gate or one water request is ever active.
module lock_sequencer #(
  parameter int GATE_CYCLES   = 8,
  parameter int ENTER_TIMEOUT = 100,
  parameter int WATER_TIMEOUT = 200,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic arrive_up,
  input  logic arrive_down,
  input  logic boat_in,
  input  logic water_high,
  input  logic water_low,
  output logic w_up,
  output logic w_down,
  output logic gate_up_cmd,
  output logic gate_down_cmd,
  output logic busy,
  output logic fault
);

  typedef enum logic [2:0] {IDLE, MOVE, OPEN, WAIT, CLOSE, FAULT} state_t;

  localparam logic [CNT_W-1:0] GATE_LAST  = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTER_LAST = CNT_W'(ENTER_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WATER_LAST = CNT_W'(WATER_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state;
  logic             level;
  logic             pend_up;
  logic             pend_down;
  logic             side;
  logic             phase;
  logic             abandoned;
  logic [CNT_W-1:0] cnt;

  logic pick_side;
  logic target_flag;

  // side and level share an encoding (1 = high/up), so side == level means no water move
  assign pick_side   = (pend_up & level)    ? 1'b1 :
                       (pend_down & ~level) ? 1'b0 :
                       ~pend_down;
  assign target_flag = side ? water_high : water_low;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      level         <= 1'b0;
      pend_up       <= 1'b0;
      pend_down     <= 1'b0;
      side          <= 1'b0;
      phase         <= 1'b0;
      abandoned     <= 1'b0;
      cnt           <= '0;
      w_up          <= 1'b0;
      w_down        <= 1'b0;
      gate_up_cmd   <= 1'b0;
      gate_down_cmd <= 1'b0;
      busy          <= 1'b0;
      fault         <= 1'b0;
    end else begin
      w_up   <= 1'b0;
      w_down <= 1'b0;
      cnt    <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      if (arrive_up)   pend_up   <= 1'b1;
      if (arrive_down) pend_down <= 1'b1;

      case (state)
        IDLE: begin
          if (pend_up || pend_down) begin
            side      <= pick_side;
            phase     <= 1'b0;
            abandoned <= 1'b0;
            busy      <= 1'b1;
            cnt       <= '0;
            if (pick_side) pend_up   <= arrive_up;
            else           pend_down <= arrive_down;
            if (pick_side == level) begin
              state         <= OPEN;
              gate_up_cmd   <= pick_side;
              gate_down_cmd <= ~pick_side;
            end else begin
              state  <= MOVE;
              w_up   <= pick_side;
              w_down <= ~pick_side;
            end
          end
        end

        MOVE: begin
          // water stage still reports the old level in the first cycle
          if ((cnt != '0) && target_flag) begin
            level         <= side;
            state         <= OPEN;
            cnt           <= '0;
            gate_up_cmd   <= side;
            gate_down_cmd <= ~side;
          end else if (cnt == WATER_LAST) begin
            state <= FAULT;
            fault <= 1'b1;
            cnt   <= '0;
          end
        end

        OPEN: begin
          if (cnt == GATE_LAST) begin
            state <= WAIT;
            cnt   <= '0;
          end
        end

        WAIT: begin
          if (phase ? !boat_in : boat_in) begin
            state         <= CLOSE;
            cnt           <= '0;
            gate_up_cmd   <= 1'b0;
            gate_down_cmd <= 1'b0;
          end else if (!phase && (cnt == ENTER_LAST)) begin
            state         <= CLOSE;
            abandoned     <= 1'b1;
            cnt           <= '0;
            gate_up_cmd   <= 1'b0;
            gate_down_cmd <= 1'b0;
          end
        end

        CLOSE: begin
          if (cnt == GATE_LAST) begin
            cnt <= '0;
            if (!phase && !abandoned) begin
              side   <= ~side;
              phase  <= 1'b1;
              state  <= MOVE;
              w_up   <= ~side;
              w_down <= side;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        FAULT: begin
          gate_up_cmd   <= 1'b0;
          gate_down_cmd <= 1'b0;
          fault         <= 1'b1;
        end

        default: begin
          state         <= FAULT;
          fault         <= 1'b1;
          gate_up_cmd   <= 1'b0;
          gate_down_cmd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: one table-driven full passage, then directed
// sequences for timeouts, fault, simultaneous arrivals and mid-passage reset.
module tb_lock_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic arrive_up = 1'b0, arrive_down = 1'b0, boat_in = 1'b0;
  logic water_high = 1'b0, water_low = 1'b1;
  logic w_up, w_down, gate_up_cmd, gate_down_cmd, busy, fault;

  int n_checks = 0;
  int n_pass   = 0;
  int n_wup    = 0;
  int n_wdn    = 0;

  lock_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .arrive_up     (arrive_up),
    .arrive_down   (arrive_down),
    .boat_in       (boat_in),
    .water_high    (water_high),
    .water_low     (water_low),
    .w_up          (w_up),
    .w_down        (w_down),
    .gate_up_cmd   (gate_up_cmd),
    .gate_down_cmd (gate_down_cmd),
    .busy          (busy),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   n;
    logic au, ad, bi, wh, wl;
    logic e_wup, e_wdn, e_gu, e_gd, e_busy, e_fault;
  } vec_t;

  vec_t tbl [17];

  // Safety invariants and water-request pulse counting, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      if (w_up)   n_wup++;
      if (w_down) n_wdn++;
      n_checks++;
      if ((gate_up_cmd && gate_down_cmd) || (w_up && w_down) ||
          ((w_up || w_down) && (gate_up_cmd || gate_down_cmd)) ||
          (w_up && dut.level) || (w_down && !dut.level) ||
          (fault && (w_up || w_down || gate_up_cmd || gate_down_cmd)))
        $display("FAIL invariant at %0t: wup=%b wdn=%b gu=%b gd=%b level=%b fault=%b",
                 $time, w_up, w_down, gate_up_cmd, gate_down_cmd, dut.level, fault);
      else
        n_pass++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic au, input logic ad, input logic bi,
                       input logic wh, input logic wl);
    arrive_up   = au;
    arrive_down = ad;
    boat_in     = bi;
    water_high  = wh;
    water_low   = wl;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [5:0] outs();
    return {w_up, w_down, gate_up_cmd, gate_down_cmd, busy, fault};
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return w_up;
      1:       return w_down;
      2:       return gate_up_cmd;
      3:       return gate_down_cmd;
      4:       return busy;
      default: return fault;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input int bound,
                          input string name, output int n);
    n = 0;
    while (sig(sel) !== val && n < bound) begin
      tick();
      n++;
    end
    n_checks++;
    if (sig(sel) === val) n_pass++;
    else $display("FAIL %s: no event within %0d cycles, value %b, required %b",
                  name, bound, sig(sel), val);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 1);
    reset = 1'b0;
    repeat (2) tick();
    chk("reset_outputs", 32'(outs()), 32'h0);
    chk("reset_level", 32'(dut.level), 32'h0);
    reset = 1'b1;
    n_wup = 0;
    n_wdn = 0;
  endtask

  initial begin
    int n;

    //            n  au ad bi wh wl  wup wdn gu gd busy fault
    tbl[0]  = '{1, 0, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1, 0};
    tbl[2]  = '{7, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1, 0};
    tbl[4]  = '{5, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1, 0};
    tbl[5]  = '{1, 0, 0, 1, 0, 1,   0, 0, 0, 0, 1, 0};
    tbl[6]  = '{7, 0, 0, 1, 0, 1,   0, 0, 0, 0, 1, 0};
    tbl[7]  = '{1, 0, 0, 1, 0, 1,   1, 0, 0, 0, 1, 0};
    tbl[8]  = '{1, 0, 0, 1, 1, 0,   0, 0, 0, 0, 1, 0};
    tbl[9]  = '{3, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0};
    tbl[10] = '{1, 0, 0, 1, 1, 0,   0, 0, 1, 0, 1, 0};
    tbl[11] = '{7, 0, 0, 1, 1, 0,   0, 0, 1, 0, 1, 0};
    tbl[12] = '{1, 0, 0, 1, 1, 0,   0, 0, 1, 0, 1, 0};
    tbl[13] = '{3, 0, 0, 1, 1, 0,   0, 0, 1, 0, 1, 0};
    tbl[14] = '{1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0};
    tbl[15] = '{7, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0};
    tbl[16] = '{1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0};

    // Full down-to-up passage from reset, stale flag in first MOVE cycle ignored
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].au, tbl[i].ad, tbl[i].bi, tbl[i].wh, tbl[i].wl);
      repeat (tbl[i].n) tick();
      chk($sformatf("pass1_vec%0d", i), 32'(outs()),
          32'({tbl[i].e_wup, tbl[i].e_wdn, tbl[i].e_gu, tbl[i].e_gd,
               tbl[i].e_busy, tbl[i].e_fault}));
    end
    chk("pass1_level", 32'(dut.level), 32'h1);
    chk("pass1_wup_count", 32'(n_wup), 32'd1);
    chk("pass1_wdown_count", 32'(n_wdn), 32'd0);

    // Both arrivals at level 1: up served first, down stays pending
    drive(1, 1, 0, 1, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    tick();
    chk("both_up_first", 32'(outs()), 32'b001010);
    chk("both_pend_down_kept", 32'(dut.pend_down), 32'h1);
    repeat (10) tick();
    boat_in = 1'b1;
    wait_sig(2, 1'b0, 5, "both_up_close", n);
    wait_sig(1, 1'b1, 12, "both_wdown", n);
    chk("both_close_len", 32'(n), 32'd8);
    tick();
    drive(0, 0, 1, 0, 1);
    tick();
    chk("both_exit_gate_down", 32'(outs()), 32'b000110);
    repeat (10) tick();
    boat_in = 1'b0;
    wait_sig(3, 1'b0, 5, "both_exit_close", n);
    wait_sig(4, 1'b0, 12, "both_idle", n);
    chk("both_pend_down_at_idle", 32'(dut.pend_down), 32'h1);
    tick();
    chk("both_down_starts", 32'(outs()), 32'b000110);
    chk("both_pend_down_cleared", 32'(dut.pend_down), 32'h0);
    repeat (10) tick();
    boat_in = 1'b1;
    wait_sig(3, 1'b0, 5, "down_close", n);
    wait_sig(0, 1'b1, 12, "down_wup", n);
    tick();
    drive(0, 0, 1, 1, 0);
    tick();
    chk("down_exit_gate_up", 32'(outs()), 32'b001010);
    chk("down_level_high", 32'(dut.level), 32'h1);
    repeat (3) tick();

    // Reset mid-OPEN: outputs drop without waiting for a clock edge
    #2 reset = 1'b0;
    #1;
    chk("midreset_outputs", 32'(outs()), 32'h0);
    chk("midreset_level", 32'(dut.level), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Up passage from level 0: w_up, gate_up, entry, w_down, gate_down
    do_reset();
    drive(1, 0, 0, 0, 1);
    tick();
    arrive_up = 1'b0;
    tick();
    chk("up_wup_pulse", 32'(outs()), 32'b100010);
    tick();
    chk("up_wup_one_cycle", 32'(outs()), 32'b000010);
    drive(0, 0, 0, 1, 0);
    tick();
    chk("up_gate_up", 32'(outs()), 32'b001010);
    repeat (10) tick();
    chk("up_wait_holds", 32'(gate_up_cmd), 32'h1);
    boat_in = 1'b1;
    wait_sig(2, 1'b0, 5, "up_close", n);
    wait_sig(1, 1'b1, 12, "up_wdown", n);
    chk("up_close_len", 32'(n), 32'd8);
    tick();
    drive(0, 0, 1, 0, 1);
    tick();
    chk("up_gate_down", 32'(outs()), 32'b000110);
    repeat (10) tick();
    boat_in = 1'b0;
    wait_sig(3, 1'b0, 5, "up_exit_close", n);
    wait_sig(4, 1'b0, 12, "up_idle", n);
    chk("up_exit_close_len", 32'(n), 32'd8);
    chk("up_level_low", 32'(dut.level), 32'h0);
    chk("up_pulse_counts", 32'({n_wup[7:0], n_wdn[7:0]}), 32'h0101);

    // Enter timeout: gate open 8 + 100 cycles, no water request
    do_reset();
    drive(0, 1, 0, 0, 1);
    tick();
    arrive_down = 1'b0;
    tick();
    n = 0;
    while (gate_down_cmd && n < 200) begin
      tick();
      n++;
    end
    chk("abandon_gate_cycles", 32'(n), 32'd108);
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("abandon_close_cycles", 32'(n), 32'd8);
    chk("abandon_no_water", 32'({n_wup[7:0], n_wdn[7:0]}), 32'h0);
    chk("abandon_level", 32'(dut.level), 32'h0);

    // Water timeout: FAULT after 200 MOVE cycles, sticky until reset
    do_reset();
    drive(1, 0, 0, 0, 0);
    tick();
    arrive_up = 1'b0;
    tick();
    chk("fault_wup", 32'(w_up), 32'h1);
    n = 0;
    while (!fault && n < 400) begin
      tick();
      n++;
    end
    chk("fault_cycles", 32'(n), 32'd200);
    chk("fault_outputs", 32'(outs()), 32'b000011);
    drive(1, 1, 1, 1, 1);
    repeat (20) tick();
    chk("fault_sticky", 32'(outs()), 32'b000011);
    do_reset();
    tick();
    chk("fault_cleared", 32'(outs()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
